// File: rtl/morse_tone_sequencer_pkg.sv
// Shared constants, state encoding and unit-count helper for the Morse tone sequencer.
package morse_pkg;

    localparam int MAX_ELEMS        = 6;
    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } morse_state_e;

    // The multiple counter stops at (units - 1), so a phase of n units ends on its n-th tick.
    function automatic logic [1:0] units_target(input int units);
        return 2'(units - 1);
    endfunction

endpackage

// File: rtl/morse_tone_sequencer_if.sv
// Symbol handshake bundle between a symbol source (master) and the tone sequencer (slave).
interface morse_tone_sequencer_if #(
    parameter int MAX_ELEMS = morse_pkg::MAX_ELEMS
);
    localparam int LEN_W = $clog2(MAX_ELEMS + 1);

    logic                 sym_valid;
    logic                 sym_ready;
    logic [LEN_W-1:0]     sym_len;
    logic [MAX_ELEMS-1:0] sym_bits;
    logic [31:0]          unit_cycles;
    logic [31:0]          tone_div;

    modport master (
        output sym_valid, sym_len, sym_bits, unit_cycles, tone_div,
        input  sym_ready
    );

    modport slave (
        input  sym_valid, sym_len, sym_bits, unit_cycles, tone_div,
        output sym_ready
    );

endinterface

// File: rtl/morse_tone_sequencer_unit_timer.sv
// Unit timer: ticks once per Morse unit and flags when the requested number of units has elapsed.
module morse_unit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] unit_len,
    input  logic [1:0]  mult_target,
    output logic        unit_tick,
    output logic        mult_done
);

    logic [31:0] unit_cnt;
    logic [1:0]  mult_cnt;

    assign unit_tick = (unit_cnt == unit_len - 32'd1);
    assign mult_done = (mult_cnt == mult_target);

    // The multiple counter saturates at its target; the owner clears both counters at phase end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_cnt <= '0;
            mult_cnt <= '0;
        end else if (clear) begin
            unit_cnt <= '0;
            mult_cnt <= '0;
        end else if (run) begin
            if (unit_tick) begin
                unit_cnt <= '0;
                if (!mult_done)
                    mult_cnt <= mult_cnt + 2'd1;
            end else begin
                unit_cnt <= unit_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/morse_tone_sequencer.sv
// Morse tone sequencer: plays one symbol of dots/dashes with element, letter and word gaps.
// Optional MORSE_SEQ_ABORT_EN adds an abort input that returns to IDLE without sym_done.
module morse_tone_sequencer #(
    parameter int MAX_ELEMS = morse_pkg::MAX_ELEMS
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MORSE_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    morse_tone_sequencer_if.slave   sym,
    output logic                    piezo_en,
    output logic [31:0]             freq_div,
    output logic                    busy,
    output logic                    sym_done
);
    import morse_pkg::*;

    localparam int LEN_W = $clog2(MAX_ELEMS + 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] TONE = ST_TONE;
    localparam logic [1:0] GAP  = ST_GAP;

    logic [1:0]           state;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     elem_idx;
    logic [MAX_ELEMS-1:0] bits_q;
    logic [31:0]          unit_q;
    logic [1:0]           target_q;
    logic                 final_gap;

    logic                 abort_now;
    logic                 accept;
    logic [LEN_W-1:0]     len_in;
    logic [LEN_W-1:0]     next_idx;
    logic                 next_dash;
    logic                 last_elem;
    logic                 unit_tick;
    logic                 mult_done;
    logic                 phase_end;

    always_comb begin
        abort_now = 1'b0;
`ifdef MORSE_SEQ_ABORT_EN
        abort_now = abort;
`endif
        accept    = sym.sym_valid && sym.sym_ready && !abort_now;
        len_in    = (sym.sym_len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : sym.sym_len;
        next_idx  = elem_idx + LEN_W'(1);
        next_dash = bits_q[next_idx];
        last_elem = (elem_idx == len_q - LEN_W'(1));
        phase_end = (state != IDLE) && unit_tick && mult_done;
    end

    assign sym.sym_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign sym_done      = phase_end && (state == GAP) && final_gap && !abort_now;

    morse_unit_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept || phase_end || abort_now),
        .run         (busy),
        .unit_len    (unit_q),
        .mult_target (target_q),
        .unit_tick   (unit_tick),
        .mult_done   (mult_done)
    );

    // Symbol parameters are captured once at accept so the source may change them freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            piezo_en  <= 1'b0;
            freq_div  <= '0;
            len_q     <= '0;
            elem_idx  <= '0;
            bits_q    <= '0;
            unit_q    <= '0;
            target_q  <= '0;
            final_gap <= 1'b0;
        end else if (abort_now) begin
            state     <= IDLE;
            piezo_en  <= 1'b0;
            final_gap <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q    <= len_in;
                        bits_q   <= sym.sym_bits;
                        elem_idx <= '0;
                        freq_div <= sym.tone_div;
                        unit_q   <= (sym.unit_cycles == 32'd0) ? 32'd1 : sym.unit_cycles;
                        if (len_in == '0) begin
                            state     <= GAP;
                            piezo_en  <= 1'b0;
                            final_gap <= 1'b1;
                            target_q  <= units_target(WORD_GAP_UNITS);
                        end else begin
                            state     <= TONE;
                            piezo_en  <= 1'b1;
                            final_gap <= 1'b0;
                            target_q  <= units_target(sym.sym_bits[0] ? DASH_UNITS : DOT_UNITS);
                        end
                    end
                end
                TONE: begin
                    if (phase_end) begin
                        state     <= GAP;
                        piezo_en  <= 1'b0;
                        final_gap <= last_elem;
                        target_q  <= units_target(last_elem ? LETTER_GAP_UNITS : ELEM_GAP_UNITS);
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        if (final_gap) begin
                            state     <= IDLE;
                            final_gap <= 1'b0;
                        end else begin
                            state    <= TONE;
                            piezo_en <= 1'b1;
                            elem_idx <= next_idx;
                            target_q <= units_target(next_dash ? DASH_UNITS : DOT_UNITS);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    piezo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tone_sequencer.sv
// Self-checking bench for morse_tone_sequencer: vector table plus per-cycle scoreboard,
// with hand-written reset and (under MORSE_SEQ_ABORT_EN) abort sequences.
module tb_morse_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
`ifdef MORSE_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        piezo_en;
    logic [31:0] freq_div;
    logic        busy;
    logic        sym_done;

    morse_tone_sequencer_if #(.MAX_ELEMS(6)) sym ();

    morse_tone_sequencer #(.MAX_ELEMS(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef MORSE_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .sym      (sym),
        .piezo_en (piezo_en),
        .freq_div (freq_div),
        .busy     (busy),
        .sym_done (sym_done)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        en;
        logic        done;
        logic [31:0] fdiv;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  len;
        logic [5:0]  bits;
        logic [31:0] unit;
        logic [31:0] tdiv;
        int          exp_busy;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   passed = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic push_run(input logic en, input int n, input logic done_last, input logic [31:0] fdiv);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.en   = en;
            e.done = done_last && (i == n - 1);
            e.fdiv = fdiv;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_push(input vec_t v);
        int u, l, k;
        u = (v.unit == 0) ? 1 : int'(v.unit);
        l = (v.len > 3'd6) ? 6 : int'(v.len);
        if (l == 0) begin
            push_run(1'b0, 4 * u, 1'b1, v.tdiv);
        end else begin
            for (int i = 0; i < l; i++) begin
                k = v.bits[i] ? 3 : 1;
                push_run(1'b1, k * u, 1'b0, v.tdiv);
                if (i == l - 1)
                    push_run(1'b0, 3 * u, 1'b1, v.tdiv);
                else
                    push_run(1'b0, u, 1'b0, v.tdiv);
            end
        end
    endtask

    task automatic drive_and_accept(input vec_t v, output bit ok);
        int waited = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!sym.sym_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!sym.sym_ready) begin
            check_output({v.name, "_ready_timeout"}, 64'(sym.sym_ready), 64'd1);
            return;
        end
        sym.sym_valid   = 1'b1;
        sym.sym_len     = v.len;
        sym.sym_bits    = v.bits;
        sym.unit_cycles = v.unit;
        sym.tone_div    = v.tdiv;
        @(posedge clk);
        #1;
        sym.sym_valid   = 1'b0;
        sym.sym_len     = 3'($urandom);
        sym.sym_bits    = 6'($urandom);
        sym.unit_cycles = 32'($urandom_range(1, 9));
        sym.tone_div    = $urandom;
        ok = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        bit   ok;
        int   busy_cnt = 0;
        exp_t e;
        drive_and_accept(v, ok);
        if (!ok) return;
        model_push(v);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            e = exp_q.pop_front();
            check_output({v.name, "_cycle"},
                         {28'd0, piezo_en, sym_done, busy, sym.sym_ready, freq_div},
                         {28'd0, e.en, e.done, 1'b1, 1'b0, e.fdiv});
        end
        @(negedge clk);
        check_output({v.name, "_idle_after"}, {61'd0, sym.sym_ready, busy, piezo_en}, {61'd0, 3'b100});
        check_output({v.name, "_fdiv_held"}, 64'(freq_div), 64'(v.tdiv));
        check_output({v.name, "_busy_len"}, 64'(busy_cnt), 64'(v.exp_busy));
    endtask

    initial begin
        bit ok;
        int done_cnt;
        vec_t t;

        vecs[0] = '{"A_u4",    3'd2, 6'b000010, 32'd4,  32'h0000_1111, 32};
        vecs[1] = '{"E_u0",    3'd1, 6'b000000, 32'd0,  32'h0000_2222,  4};
        vecs[2] = '{"word_u10",3'd0, 6'b000000, 32'd10, 32'h0000_3333, 40};
        vecs[3] = '{"len7_u2", 3'd7, 6'b111111, 32'd2,  32'h0000_4444, 52};
        vecs[4] = '{"K_u3",    3'd3, 6'b000101, 32'd3,  32'h0000_5555, 36};
        vecs[5] = '{"dots6_u1",3'd6, 6'b000000, 32'd1,  32'h0000_6666, 14};
        vecs[6] = '{"T_u5",    3'd1, 6'b000001, 32'd5,  32'h0000_7777, 30};

        sym.sym_valid   = 1'b0;
        sym.sym_len     = '0;
        sym.sym_bits    = '0;
        sym.unit_cycles = '0;
        sym.tone_div    = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_piezo_en", 64'(piezo_en), 64'd0);
        check_output("rst_freq_div", 64'(freq_div), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_sym_done", 64'(sym_done), 64'd0);
        check_output("rst_sym_ready", 64'(sym.sym_ready), 64'd1);

        for (int i = 0; i < 7; i++)
            apply_stimulus(vecs[i]);

        // Asynchronous reset in the middle of a dash must silence the tone without waiting for a clock.
        t = '{"T_reset", 3'd1, 6'b000001, 32'd5, 32'h0000_ABCD, 30};
        drive_and_accept(t, ok);
        repeat (8) @(negedge clk);
        check_output("mid_dash_en", 64'(piezo_en), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_en", 64'(piezo_en), 64'd0);
        check_output("async_rst_fdiv", 64'(freq_div), 64'd0);
        check_output("async_rst_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        @(negedge clk);
        if (sym_done) done_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rel_ready", 64'(sym.sym_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sym_done || busy) done_cnt++;
        end
        check_output("rst_no_done", 64'(done_cnt), 64'd0);

`ifdef MORSE_SEQ_ABORT_EN
        t = '{"A_abort", 3'd2, 6'b000010, 32'd4, 32'h0000_0077, 32};
        drive_and_accept(t, ok);
        repeat (12) @(negedge clk);
        check_output("abort_pre_en", 64'(piezo_en), 64'd1);
        abort           = 1'b1;
        sym.sym_valid   = 1'b1;
        sym.sym_len     = 3'd1;
        sym.sym_bits    = 6'd0;
        sym.unit_cycles = 32'd2;
        sym.tone_div    = 32'h0000_0099;
        check_output("abort_cycle_done", 64'(sym_done), 64'd0);
        @(posedge clk);
        #1;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_en", 64'(piezo_en), 64'd0);
        check_output("abort_done", 64'(sym_done), 64'd0);
        check_output("abort_fdiv_held", 64'(freq_div), 64'h77);
        abort         = 1'b0;
        sym.sym_valid = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sym_done || busy) done_cnt++;
        end
        check_output("abort_no_done", 64'(done_cnt), 64'd0);
        apply_stimulus(vecs[1]);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/morse_tone_sequencer.md
MORSE_TONE_SEQUENCER -- requirements
Module: morse_tone_sequencer

Interface
REQ-001 SHALL have parameter MAX_ELEMS, default 6, meaning max dot/dash elements per symbol; sym_len/sym_bits widths derive from it.
REQ-002 SHALL have port clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port sym_valid  in  1  symbol offered.
REQ-005 SHALL have port sym_ready  out  1  sequencer can accept a symbol.
REQ-006 SHALL have port sym_len  in  3  element count 1..6; 0 = word-gap token.
REQ-007 SHALL have port sym_bits  in  6  bit i = element i (1 = dash, 0 = dot); element 0 sent first.
REQ-008 SHALL have port unit_cycles  in  32  clocks per Morse unit, sampled at accept.
REQ-009 SHALL have port tone_div  in  32  tone half-period divider, sampled at accept.
REQ-010 SHALL have port piezo_en  out  1  tone enable to piezo driver.
REQ-011 SHALL have port freq_div  out  32  divider to piezo driver.
REQ-012 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-013 SHALL have port sym_done  out  1  one-cycle pulse at symbol completion.

Function
REQ-014 SHALL implement states IDLE, TONE, GAP; sym_ready = (state == IDLE).
REQ-015 SHALL accept on sym_valid && sym_ready; inputs not held stable after accept are ignored.
REQ-016 SHALL latch unit_cycles at accept; value 0 treated as 1.
REQ-017 SHALL latch tone_div into freq_div at accept and hold it until the next accept.
REQ-018 SHALL clamp sym_len 7 to 6.
REQ-019 On accept of sym_len > 0: next cycle TONE, piezo_en high from cycle N+1.
REQ-020 Dot tone SHALL last 1 unit, dash 3 units, exactly unit_cycles*k clocks.
REQ-021 After a non-final element: GAP with piezo_en low for 1 unit, then TONE for the next element.
REQ-022 After the final element: GAP with piezo_en low for 3 units (letter gap).
REQ-023 On accept of sym_len == 0: go to GAP, piezo_en low for 4 units (3 + 4 = 7-unit word space).
REQ-024 SHALL pulse sym_done in the last cycle of the final gap, then return to IDLE the next cycle.
REQ-025 SHALL drive piezo_en as a registered output that is high only in TONE.
REQ-026 SHALL perform unit and multiple counting with 32-bit unit counter and 2-bit multiple counter; counters never wrap.
REQ-027 SHALL NOT accept a symbol in the same cycle sym_done is high.

Reset
REQ-028 rst_n low SHALL force IDLE, piezo_en=0, freq_div=0, busy=0, sym_done=0, sym_ready=1 after release, and clear all counters.
REQ-029 Reset mid-symbol SHALL silence the tone immediately (asynchronously) with no sym_done.

Configuration
REQ-030 With MORSE_SEQ_ABORT_EN defined: add input abort (1 bit); abort high in any state forces IDLE next cycle with piezo_en=0 and no sym_done.
REQ-031 Abort SHALL take priority over accept in the same cycle; freq_div is held.
REQ-032 Without MORSE_SEQ_ABORT_EN: the abort port and logic are absent; all else is identical.

Structure
REQ-033 Package morse_pkg SHALL hold the state enum and constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=4, MAX_ELEMS=6.
REQ-034 SHALL contain one sub-module, morse_unit_timer, which generates a unit tick plus a multiple-count-reached flag.
REQ-035 SHALL NOT instantiate the piezo driver; the top level connects piezo_en and freq_div to it.

Verification
REQ-036 unit_cycles=4, 'A' (len=2, bits=0b10), accept at cycle 0 -> en high cycles 1-4, low 5-8, high 9-20, low 21-32, sym_done at 32, ready at 33.
REQ-037 unit_cycles=0, 'E' (len=1, bits=0) -> en high exactly 1 cycle, then low 3 cycles, then sym_done.
REQ-038 len=0, unit_cycles=10 -> en never high, busy 40 cycles, sym_done on 40th cycle.
REQ-039 len=7, bits=0x3F, unit_cycles=2 -> six dashes of 6 clocks each, separated by 2-clock gaps; the seventh element is ignored.
REQ-040 rst_n low mid-dash -> piezo_en and freq_div 0 immediately, no sym_done, ready after release.
REQ-041 MORSE_SEQ_ABORT_EN, abort during the second element of 'A' with sym_valid high -> IDLE next cycle, en 0, symbol not accepted that cycle.
